// File: rtl/instr_mem_loader_if.sv
// Word stream into the loader plus its byte write port toward the instruction memory.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_word, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_word, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Serializes 32-bit instruction words into little-endian byte writes starting at address 0.
module instr_mem_loader #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_mem_loader_if.slave io,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] word_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam int                WORDS     = DEPTH_BYTES / 4;
    localparam logic [ADDR_W-3:0] LAST_IDX  = (ADDR_W-2)'(WORDS - 1);
    localparam logic [ADDR_W-2:0] COUNT_MAX = (ADDR_W-1)'(WORDS);

    logic [2:0]        state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-3:0] word_idx;
    logic              last_q;
    logic [31:0]       word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            word_count <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        word_idx   <= '0;
                        word_count <= '0;
                        state      <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (io.in_valid) begin
                        last_q   <= io.in_last;
                        byte_cnt <= 2'd0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        // word_idx holds at the top slot so it can never wrap
                        if (word_idx != LAST_IDX)
                            word_idx <= word_idx + 1'b1;
                        if (word_count != COUNT_MAX)
                            word_count <= word_count + 1'b1;
                        if (last_q)
                            state <= S_DONE;
                        else if (word_idx == LAST_IDX)
                            state <= S_ERROR;
                        else
                            state <= S_ACCEPT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data holding register: only meaningful while in WRITE, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_ACCEPT && io.in_valid)
            word_q <= io.in_word;
    end

    always_comb begin
        io.in_ready  = (state == S_ACCEPT);
        io.mem_we    = (state == S_WRITE);
        io.mem_addr  = '0;
        io.mem_wdata = 8'd0;
        if (state == S_WRITE) begin
            io.mem_addr  = {word_idx, byte_cnt};
            io.mem_wdata = word_q[{byte_cnt, 3'b000} +: 8];
        end
        busy  = (state == S_ACCEPT) || (state == S_WRITE);
        done  = (state == S_DONE);
        error = (state == S_ERROR);
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench: a 1 KiB loader for reset/stream/restart cases and a 16-byte one for fill limits.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [8:0] wc_a;
    logic [2:0] wc_b;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    instr_mem_loader_if #(.ADDR_W(10)) bus_a ();
    instr_mem_loader_if #(.ADDR_W(4))  bus_b ();

    instr_mem_loader #(.DEPTH_BYTES(1024), .ADDR_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .io(bus_a.slave),
        .busy(busy_a), .done(done_a), .error(error_a), .word_count(wc_a)
    );

    instr_mem_loader #(.DEPTH_BYTES(16), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .io(bus_b.slave),
        .busy(busy_b), .done(done_b), .error(error_b), .word_count(wc_b)
    );

    always #5 clk = ~clk;

    // Byte-addressed memories receiving the write ports, plus write bookkeeping.
    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:15];
    int wr_a = 0;
    int wr_b = 0;
    int last_addr_a = -1;
    int overlap = 0;

    always @(posedge clk) begin
        if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            wr_a <= wr_a + 1;
            last_addr_a <= int'(bus_a.mem_addr);
        end
        if (bus_b.mem_we) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
            wr_b <= wr_b + 1;
        end
        if ((bus_a.mem_we && bus_a.in_ready) || (bus_b.mem_we && bus_b.in_ready))
            overlap <= overlap + 1;
    end

    function automatic logic [31:0] fetch_a(input int i);
        return {mem_a[4*i+3], mem_a[4*i+2], mem_a[4*i+1], mem_a[4*i]};
    endfunction

    function automatic logic [31:0] fetch_b(input int i);
        return {mem_b[4*i+3], mem_b[4*i+2], mem_b[4*i+1], mem_b[4*i]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_word(input bit b, input logic [31:0] w, input logic l);
        int n = 0;
        while (((b ? bus_b.in_ready : bus_a.in_ready) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {31'd0, (b ? bus_b.in_ready : bus_a.in_ready)}, 32'd1);
        if (b) begin
            bus_b.in_valid = 1'b1; bus_b.in_word = w; bus_b.in_last = l;
        end else begin
            bus_a.in_valid = 1'b1; bus_a.in_word = w; bus_a.in_last = l;
        end
        tick();
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    logic [7:0]  exp_bytes [4];
    logic [31:0] ovf_words [4];
    logic [31:0] fill_words [4];
    int wr_snap;

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_word = 32'd0; bus_a.in_last = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_word = 32'd0; bus_b.in_last = 1'b0;
        exp_bytes  = '{8'h33, 8'h05, 8'hC5, 8'h00};
        ovf_words  = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        fill_words = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};

        repeat (2) tick();
        chk("rst_busy",   {31'd0, busy_a}, 32'd0);
        chk("rst_ready",  {31'd0, bus_a.in_ready}, 32'd0);
        chk("rst_wcount", {23'd0, wc_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset asserted while byte 2 of a word is on the write port
        pulse_start(1'b0);
        chk("start_ready", {31'd0, bus_a.in_ready}, 32'd1);
        send_word(1'b0, 32'h12345678, 1'b1);
        tick();
        tick();
        chk("midwr_addr",  {22'd0, bus_a.mem_addr}, 32'd2);
        chk("midwr_wdata", {24'd0, bus_a.mem_wdata}, 32'h34);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",    {31'd0, bus_a.mem_we}, 32'd0);
        chk("arst_addr",  {22'd0, bus_a.mem_addr}, 32'd0);
        chk("arst_wdata", {24'd0, bus_a.mem_wdata}, 32'd0);
        chk("arst_busy",  {31'd0, busy_a}, 32'd0);
        chk("arst_done",  {31'd0, done_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1'b0);
        send_word(1'b0, 32'h12345678, 1'b1);
        repeat (4) tick();
        chk("post_rst_done", {31'd0, done_a}, 32'd1);
        chk("post_rst_word", fetch_a(0), 32'h12345678);

        // Single word, byte by byte
        pulse_start(1'b0);
        chk("restart_clear_done", {31'd0, done_a}, 32'd0);
        send_word(1'b0, 32'h00C50533, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("sw_we",    {31'd0, bus_a.mem_we}, 32'd1);
            chk("sw_addr",  {22'd0, bus_a.mem_addr}, k);
            chk("sw_wdata", {24'd0, bus_a.mem_wdata}, {24'd0, exp_bytes[k]});
            if (k < 3) chk("sw_busy_mid", {31'd0, busy_a}, 32'd1);
            tick();
        end
        chk("sw_wcount", {23'd0, wc_a}, 32'd1);
        chk("sw_done",   {31'd0, done_a}, 32'd1);
        chk("sw_busy",   {31'd0, busy_a}, 32'd0);
        chk("sw_fetch",  fetch_a(0), 32'h00C50533);
        chk("sw_idle_we", {31'd0, bus_a.mem_we}, 32'd0);

        // Stream with idle gaps and a start pulse ignored mid-write
        pulse_start(1'b0);
        wr_snap = wr_a;
        repeat (2) tick();
        send_word(1'b0, 32'h11111111, 1'b0);
        send_word(1'b0, 32'h22222222, 1'b0);
        pulse_start(1'b0);
        chk("ign_start_busy", {31'd0, busy_a}, 32'd1);
        repeat (6) tick();
        send_word(1'b0, 32'h33333333, 1'b1);
        repeat (4) tick();
        chk("st_wcount", {23'd0, wc_a}, 32'd3);
        chk("st_done",   {31'd0, done_a}, 32'd1);
        chk("st_writes", wr_a - wr_snap, 32'd12);
        chk("st_lastad", last_addr_a, 32'd11);
        chk("st_word0",  fetch_a(0), 32'h11111111);
        chk("st_word1",  fetch_a(1), 32'h22222222);
        chk("st_word2",  fetch_a(2), 32'h33333333);

        // Restart after DONE
        pulse_start(1'b0);
        chk("rs_done",   {31'd0, done_a}, 32'd0);
        chk("rs_wcount", {23'd0, wc_a}, 32'd0);
        send_word(1'b0, 32'hCAFEF00D, 1'b1);
        repeat (4) tick();
        chk("rs_wcount1", {23'd0, wc_a}, 32'd1);
        chk("rs_lastad",  last_addr_a, 32'd3);
        chk("rs_word0",   fetch_a(0), 32'hCAFEF00D);
        chk("rs_word1",   fetch_a(1), 32'h22222222);

        // Overflow of a 16-byte memory
        pulse_start(1'b1);
        wr_snap = wr_b;
        for (int i = 0; i < 4; i++) send_word(1'b1, ovf_words[i], 1'b0);
        repeat (4) tick();
        chk("ov_error",  {31'd0, error_b}, 32'd1);
        chk("ov_done",   {31'd0, done_b}, 32'd0);
        chk("ov_wcount", {29'd0, wc_b}, 32'd4);
        chk("ov_ready",  {31'd0, bus_b.in_ready}, 32'd0);
        bus_b.in_valid = 1'b1; bus_b.in_word = 32'hDEADBEEF; bus_b.in_last = 1'b0;
        repeat (6) tick();
        chk("ov_writes",  wr_b - wr_snap, 32'd16);
        chk("ov_we",      {31'd0, bus_b.mem_we}, 32'd0);
        chk("ov_ready2",  {31'd0, bus_b.in_ready}, 32'd0);
        chk("ov_word3",   fetch_b(3), 32'h0F0E0D0C);
        chk("ov_word0",   fetch_b(0), 32'h03020100);
        bus_b.in_valid = 1'b0;

        // Exact fill: last word lands in the final slot
        pulse_start(1'b1);
        chk("ef_err_clr", {31'd0, error_b}, 32'd0);
        for (int i = 0; i < 4; i++) send_word(1'b1, fill_words[i], (i == 3));
        repeat (4) tick();
        chk("ef_done",   {31'd0, done_b}, 32'd1);
        chk("ef_error",  {31'd0, error_b}, 32'd0);
        chk("ef_wcount", {29'd0, wc_b}, 32'd4);
        chk("ef_word3",  fetch_b(3), 32'h00FFEEDD);

        chk("ready_we_overlap", overlap, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
